// File: rtl/sva_thread_scheduler.sv
// Thread-context scheduler for an SVA checker: on each sample tick, walks every
// live thread through a shared next-state evaluator, then spawns a new attempt.
module sva_thread_scheduler #(
  parameter int unsigned SLOTS      = 4,
  parameter int unsigned STATE_W    = 4,
  parameter int unsigned INIT_STATE = 0,
  parameter int unsigned TS_W       = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                       gclk,
  input  logic                       grst,
  input  logic                       sample_vld,
  input  logic                       spawn_en,
  input  logic                       clr,
  output logic                       ev_vld,
  output logic                       ev_spawn,
  output logic [$clog2(SLOTS)-1:0]   ev_slot,
  output logic [STATE_W-1:0]         ev_state,
  output logic [TS_W-1:0]            ev_start,
  input  logic [STATE_W-1:0]         ev_nxt_state,
  input  logic                       ev_nxt_active,
  input  logic                       ev_succ,
  input  logic                       ev_fail,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(SLOTS):0]     active_cnt,
  output logic [CNT_W-1:0]           succ_cnt,
  output logic [CNT_W-1:0]           fail_cnt,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       overflow,
  output logic                       sample_miss
);
  localparam int unsigned SLW = $clog2(SLOTS);
  localparam int unsigned ACW = $clog2(SLOTS) + 1;

  typedef enum logic [1:0] {IDLE, SCAN, SPAWN} state_t;

  state_t             state;
  logic [SLOTS-1:0]   act_mask, scan_mask, scan_rest;
  logic [STATE_W-1:0] slot_state [SLOTS];
  logic [TS_W-1:0]    slot_start [SLOTS];
  logic [TS_W-1:0]    ts, ts_lat;
  logic               spawn_lat;
  logic [SLW-1:0]     scan_idx, free_idx;
  logic               free_any;

  // Priority pickers: iterate high-to-low so the lowest index wins.
  always_comb begin
    scan_idx = '0;
    free_idx = '0;
    free_any = 1'b0;
    for (int unsigned i = SLOTS; i > 0; i--) begin
      if (scan_mask[i-1]) scan_idx = SLW'(i-1);
      if (!act_mask[i-1]) begin
        free_idx = SLW'(i-1);
        free_any = 1'b1;
      end
    end
    scan_rest = scan_mask;
    scan_rest[scan_idx] = 1'b0;
  end

  always_comb begin
    active_cnt = '0;
    for (int unsigned i = 0; i < SLOTS; i++)
      active_cnt = active_cnt + ACW'(act_mask[i]);
  end

  always_comb begin
    ev_vld   = 1'b0;
    ev_spawn = 1'b0;
    ev_slot  = '0;
    ev_state = '0;
    ev_start = '0;
    if (state == SCAN) begin
      ev_vld   = 1'b1;
      ev_slot  = scan_idx;
      ev_state = slot_state[scan_idx];
      ev_start = slot_start[scan_idx];
    end else if (state == SPAWN && spawn_lat && free_any) begin
      ev_vld   = 1'b1;
      ev_spawn = 1'b1;
      ev_slot  = free_idx;
      ev_state = STATE_W'(INIT_STATE);
      ev_start = ts_lat;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      state       <= IDLE;
      act_mask    <= '0;
      scan_mask   <= '0;
      ts          <= '0;
      ts_lat      <= '0;
      spawn_lat   <= 1'b0;
      done        <= 1'b0;
      succ_cnt    <= '0;
      fail_cnt    <= '0;
      drop_cnt    <= '0;
      overflow    <= 1'b0;
      sample_miss <= 1'b0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        slot_state[i] <= '0;
        slot_start[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_vld) begin
            spawn_lat <= spawn_en;
            ts_lat    <= ts;
            ts        <= ts + TS_W'(1);
            scan_mask <= act_mask;
            state     <= (|act_mask) ? SCAN : SPAWN;
          end
        end
        SCAN: begin
          scan_mask <= scan_rest;
          if (ev_nxt_active) slot_state[scan_idx] <= ev_nxt_state;
          else               act_mask[scan_idx]   <= 1'b0;
          if (scan_rest == '0) state <= SPAWN;
        end
        SPAWN: begin
          if (spawn_lat) begin
            if (free_any) begin
              slot_start[free_idx] <= ts_lat;
              if (ev_nxt_active) begin
                act_mask[free_idx]   <= 1'b1;
                slot_state[free_idx] <= ev_nxt_state;
              end
            end else begin
              overflow <= 1'b1;
              if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
            end
          end
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (ev_vld && ev_succ && succ_cnt != '1) succ_cnt <= succ_cnt + CNT_W'(1);
      if (ev_vld && ev_fail && fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
      if (sample_vld && state != IDLE) sample_miss <= 1'b1;

      // Later assignments override: a clear drops any same-cycle increment.
      if (clr) begin
        succ_cnt    <= '0;
        fail_cnt    <= '0;
        drop_cnt    <= '0;
        overflow    <= 1'b0;
        sample_miss <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sva_thread_scheduler.sv
// Scoreboard bench for sva_thread_scheduler: a reference model predicts every
// evaluator request and the counter/flag state after each sample tick.
module tb_sva_thread_scheduler;
  logic        gclk = 1'b0;
  logic        grst;
  logic        sample_vld, spawn_en, clr;
  logic        ev_vld, ev_spawn;
  logic [1:0]  ev_slot;
  logic [3:0]  ev_state;
  logic [7:0]  ev_start;
  logic [3:0]  ev_nxt_state;
  logic        ev_nxt_active, ev_succ, ev_fail;
  logic        busy, done;
  logic [2:0]  active_cnt;
  logic [15:0] succ_cnt, fail_cnt, drop_cnt;
  logic        overflow, sample_miss;

  sva_thread_scheduler #(
    .SLOTS(4), .STATE_W(4), .INIT_STATE(0), .TS_W(8), .CNT_W(16)
  ) dut (
    .gclk(gclk), .grst(grst), .sample_vld(sample_vld), .spawn_en(spawn_en), .clr(clr),
    .ev_vld(ev_vld), .ev_spawn(ev_spawn), .ev_slot(ev_slot), .ev_state(ev_state),
    .ev_start(ev_start), .ev_nxt_state(ev_nxt_state), .ev_nxt_active(ev_nxt_active),
    .ev_succ(ev_succ), .ev_fail(ev_fail), .busy(busy), .done(done),
    .active_cnt(active_cnt), .succ_cnt(succ_cnt), .fail_cnt(fail_cnt),
    .drop_cnt(drop_cnt), .overflow(overflow), .sample_miss(sample_miss)
  );

  always #5 gclk = ~gclk;

  int n_chk = 0;
  int n_fail = 0;

  // Evaluator stand-in: every request advances the state by 2; a chosen slot fails.
  logic       fail_en = 1'b0;
  logic [1:0] fail_slot = 2'd0;
  logic       succ_en = 1'b0;
  always_comb begin
    ev_nxt_state  = ev_state + 4'd2;
    ev_nxt_active = 1'b1;
    ev_fail       = 1'b0;
    ev_succ       = succ_en & ev_vld;
    if (ev_vld && !ev_spawn && fail_en && ev_slot == fail_slot) begin
      ev_nxt_active = 1'b0;
      ev_fail       = 1'b1;
    end
  end

  typedef struct packed {
    logic [1:0] slot;
    logic [3:0] st;
    logic [7:0] start;
    logic       spawn;
  } ev_t;
  ev_t exp_q[$];
  ev_t got_e, exp_e;

  bit         m_act   [4];
  logic [3:0] m_st    [4];
  logic [7:0] m_start [4];
  logic [7:0] m_ts;
  int         m_succ, m_fail, m_drop;
  bit         m_ovf;

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < 4; i++) c += int'(m_act[i]);
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_act[i] = 1'b0; m_st[i] = '0; m_start[i] = '0;
    end
    m_ts = '0; m_succ = 0; m_fail = 0; m_drop = 0; m_ovf = 1'b0;
  endtask

  // Predicts one accepted tick: pushes expected requests, updates model state.
  task automatic model_tick(input bit sp, output int k);
    int f;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_act[i]) begin
        exp_q.push_back('{slot: 2'(i), st: m_st[i], start: m_start[i], spawn: 1'b0});
        k++;
        if (succ_en) m_succ++;
        if (fail_en && fail_slot == 2'(i)) begin
          m_act[i] = 1'b0;
          m_fail++;
        end else begin
          m_st[i] = m_st[i] + 4'd2;
        end
      end
    end
    if (sp) begin
      f = -1;
      for (int i = 3; i >= 0; i--) if (!m_act[i]) f = i;
      if (f >= 0) begin
        exp_q.push_back('{slot: 2'(f), st: 4'd0, start: m_ts, spawn: 1'b1});
        m_act[f] = 1'b1; m_st[f] = 4'd2; m_start[f] = m_ts;
        if (succ_en) m_succ++;
      end else begin
        m_drop++;
        m_ovf = 1'b1;
      end
    end
    m_ts = m_ts + 8'd1;
  endtask

  task automatic do_reset();
    grst = 1'b1; sample_vld = 1'b0; spawn_en = 1'b0; clr = 1'b0;
    repeat (3) @(posedge gclk);
    #1 grst = 1'b0;
    model_clear();
    exp_q.delete();
  endtask

  // Drives one tick; cyc counts edges after the sampling edge until done is seen.
  // With miss set, sample_vld is re-asserted on the first busy cycle.
  task automatic run_tick(input bit sp, input bit miss, output int k, output int cyc);
    model_tick(sp, k);
    @(posedge gclk); #1;
    sample_vld = 1'b1; spawn_en = sp;
    @(posedge gclk); #1;
    sample_vld = miss; spawn_en = 1'b0;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge gclk); #1;
      sample_vld = 1'b0;
      cyc++;
    end
  endtask

  always @(negedge gclk) begin
    if (!grst) begin
      n_chk++;
      got_e = '{slot: ev_slot, st: ev_state, start: ev_start, spawn: ev_spawn};
      if (ev_vld) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL ev_unexpected: got slot=%0d state=%0d start=%0d spawn=%0d, required no request",
                   ev_slot, ev_state, ev_start, ev_spawn);
        end else begin
          exp_e = exp_q.pop_front();
          if (got_e !== exp_e) begin
            n_fail++;
            $display("FAIL ev_req: got slot=%0d state=%0d start=%0d spawn=%0d, required slot=%0d state=%0d start=%0d spawn=%0d",
                     ev_slot, ev_state, ev_start, ev_spawn, exp_e.slot, exp_e.st, exp_e.start, exp_e.spawn);
          end
        end
      end else if (got_e !== '0) begin
        n_fail++;
        $display("FAIL ev_idle_zero: got %h, required 0", got_e);
      end
    end
  end

  task automatic test_reset();
    int k, cyc;
    do_reset();
    n_chk++;
    if ({ev_vld, busy, done, active_cnt, overflow, sample_miss} !== '0) begin
      n_fail++;
      $display("FAIL reset_flags: got vld/busy/done/cnt/ovf/miss=%b, required 0",
               {ev_vld, busy, done, active_cnt, overflow, sample_miss});
    end
    n_chk++;
    if ({succ_cnt, fail_cnt, drop_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_counters: got %h, required 0", {succ_cnt, fail_cnt, drop_cnt});
    end
    run_tick(1'b0, 1'b0, k, cyc);
    n_chk++;
    if (cyc != k + 1) begin
      n_fail++;
      $display("FAIL empty_tick_latency: got %0d, required %0d", cyc, k + 1);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_tick_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_spawn();
    int k, cyc;
    do_reset();
    for (int t = 0; t < 2; t++) begin
      run_tick(1'b1, 1'b0, k, cyc);
      n_chk++;
      if (cyc != k + 1) begin
        n_fail++;
        $display("FAIL spawn_latency%0d: got %0d, required %0d", t, cyc, k + 1);
      end
      n_chk++;
      if (active_cnt !== 3'(m_cnt())) begin
        n_fail++;
        $display("FAIL spawn_active%0d: got %0d, required %0d", t, active_cnt, m_cnt());
      end
      n_chk++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL spawn_missing%0d: got %0d requests outstanding, required 0", t, exp_q.size());
      end
    end
  endtask

  task automatic test_overflow();
    int k, cyc;
    for (int t = 0; t < 3; t++) run_tick(1'b1, 1'b0, k, cyc);
    n_chk++;
    if (cyc != 5) begin
      n_fail++;
      $display("FAIL ovf_latency: got %0d, required 5", cyc);
    end
    n_chk++;
    if (drop_cnt !== 16'(m_drop) || overflow !== m_ovf) begin
      n_fail++;
      $display("FAIL ovf_drop: got drop=%0d ovf=%b, required drop=%0d ovf=%b", drop_cnt, overflow, m_drop, m_ovf);
    end
    n_chk++;
    if (active_cnt !== 3'd4 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL ovf_active: got %0d (pending %0d), required 4 (pending 0)", active_cnt, exp_q.size());
    end
  endtask

  task automatic test_fail_reuse();
    int k, cyc;
    do_reset();
    for (int t = 0; t < 3; t++) run_tick(1'b1, 1'b0, k, cyc);
    fail_en = 1'b1; fail_slot = 2'd1;
    run_tick(1'b1, 1'b0, k, cyc);
    fail_en = 1'b0;
    n_chk++;
    if (cyc != 4) begin
      n_fail++;
      $display("FAIL reuse_latency: got %0d, required 4", cyc);
    end
    n_chk++;
    if (fail_cnt !== 16'(m_fail)) begin
      n_fail++;
      $display("FAIL reuse_fail_cnt: got %0d, required %0d", fail_cnt, m_fail);
    end
    n_chk++;
    if (active_cnt !== 3'd3 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reuse_active: got %0d (pending %0d), required 3 (pending 0)", active_cnt, exp_q.size());
    end
  endtask

  task automatic test_misuse();
    int k, cyc;
    succ_en = 1'b1;
    run_tick(1'b0, 1'b1, k, cyc);
    succ_en = 1'b0;
    n_chk++;
    if (sample_miss !== 1'b1 || cyc != 4) begin
      n_fail++;
      $display("FAIL miss_flag: got miss=%b cyc=%0d, required miss=1 cyc=4", sample_miss, cyc);
    end
    n_chk++;
    if (succ_cnt !== 16'(m_succ)) begin
      n_fail++;
      $display("FAIL miss_succ_cnt: got %0d, required %0d", succ_cnt, m_succ);
    end
    @(posedge gclk); #1 clr = 1'b1;
    @(posedge gclk); #1 clr = 1'b0;
    m_succ = 0; m_fail = 0; m_drop = 0; m_ovf = 1'b0;
    n_chk++;
    if ({succ_cnt, fail_cnt, drop_cnt, overflow, sample_miss} !== '0) begin
      n_fail++;
      $display("FAIL clr_zero: got succ=%0d fail=%0d drop=%0d ovf=%b miss=%b, required all 0",
               succ_cnt, fail_cnt, drop_cnt, overflow, sample_miss);
    end
    n_chk++;
    if (active_cnt !== 3'd3) begin
      n_fail++;
      $display("FAIL clr_keeps_threads: got %0d, required 3", active_cnt);
    end
    // Spawn start timestamp shows whether the ignored tick advanced the counter.
    run_tick(1'b1, 1'b0, k, cyc);
    n_chk++;
    if (active_cnt !== 3'd4 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL miss_ts_spawn: got active=%0d pending=%0d, required 4 / 0", active_cnt, exp_q.size());
    end
  endtask

  task automatic test_abort();
    int k, cyc;
    model_tick(1'b0, k);
    @(posedge gclk); #1 sample_vld = 1'b1;
    @(posedge gclk); #1 sample_vld = 1'b0;
    @(posedge gclk); #1;
    @(posedge gclk); #1 grst = 1'b1;
    #1;
    n_chk++;
    if (active_cnt !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: got active=%0d busy=%b done=%b, required 0/0/0", active_cnt, busy, done);
    end
    n_chk++;
    if (exp_q.size() != 2) begin
      n_fail++;
      $display("FAIL abort_progress: got %0d requests outstanding, required 2", exp_q.size());
    end
    exp_q.delete();
    repeat (2) @(posedge gclk);
    #1 grst = 1'b0;
    model_clear();
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %b, required 0", done);
    end
    run_tick(1'b1, 1'b0, k, cyc);
    n_chk++;
    if (cyc != 1 || active_cnt !== 3'd1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_respawn: got cyc=%0d active=%0d pending=%0d, required 1/1/0", cyc, active_cnt, exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    grst = 1'b1; sample_vld = 1'b0; spawn_en = 1'b0; clr = 1'b0;
    test_reset();
    test_spawn();
    test_overflow();
    test_fail_reuse();
    test_misuse();
    test_abort();
    repeat (2) @(posedge gclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
